// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding-select
// encodings, memory-wait FSM states and the pipeline control bundle.
package hazard_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  localparam logic [1:0] FWD_ID  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam pipe_ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

endpackage

// File: rtl/forward_sel_unit.sv
// Per-operand forwarding select: picks the youngest in-flight producer of the
// EX source register, never forwarding x0.
module forward_sel_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] i_src,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_wb_reg_write,
  output logic [1:0]            o_fwd_sel
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    o_fwd_sel = FWD_ID;
    if (i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == i_src)) begin
      o_fwd_sel = FWD_MEM;
    end else if (i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == i_src)) begin
      o_fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// 5-stage pipeline hazard controller: forwarding, load-use bubbles, branch
// flushes, memory-wait freeze with timeout watchdog. Define HAZARD_PERF_CNT_EN to build the counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic                  mem_access,
  input  logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;
  logic              w_freeze;
  logic              w_load_use;
  pipe_ctrl_t        w_ctrl;
  hz_state_e         r_state;
  hz_state_e         w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              r_mem_timeout;

  // No hazard decision depends on whether the EX instruction writes rd.
  logic w_unused_ex_reg_write;
  assign w_unused_ex_reg_write = ex_reg_write;

  forward_sel_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .i_src          (ex_rs1),
    .i_mem_rd       (mem_rd),
    .i_mem_reg_write(mem_reg_write),
    .i_wb_rd        (wb_rd),
    .i_wb_reg_write (wb_reg_write),
    .o_fwd_sel      (w_fwd_a)
  );

  forward_sel_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .i_src          (ex_rs2),
    .i_mem_rd       (mem_rd),
    .i_mem_reg_write(mem_reg_write),
    .i_wb_rd        (wb_rd),
    .i_wb_reg_write (wb_reg_write),
    .o_fwd_sel      (w_fwd_b)
  );

  assign fwd_a_sel = rst ? FWD_ID : w_fwd_a;
  assign fwd_b_sel = rst ? FWD_ID : w_fwd_b;

  assign w_freeze   = mem_access && !mem_ready;
  assign w_load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) ||
                       (id_use_rs2 && (ex_rd == id_rs2)));

  // Strict priority: reset bubbles, freeze, taken branch, load-use bubble.
  always_comb begin
    w_ctrl = CTRL_RUN;
    if (rst) begin
      w_ctrl = CTRL_FLUSH;
    end else if (w_freeze) begin
      w_ctrl = CTRL_FREEZE;
    end else if (ex_branch_taken) begin
      w_ctrl = CTRL_FLUSH;
    end else if (w_load_use) begin
      w_ctrl = CTRL_BUBBLE;
    end
  end

  assign pc_en      = w_ctrl.pc_en;
  assign ifid_en    = w_ctrl.ifid_en;
  assign idex_en    = w_ctrl.idex_en;
  assign exmem_en   = w_ctrl.exmem_en;
  assign memwb_en   = w_ctrl.memwb_en;
  assign ifid_flush = w_ctrl.ifid_flush;
  assign idex_flush = w_ctrl.idex_flush;

  // Leaving MEM_WAIT whenever the freeze is gone also covers mem_access dropping.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      RUN: begin
        if (w_freeze) begin
          w_state_nxt    = MEM_WAIT;
          w_wait_cnt_nxt = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!w_freeze) begin
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt != WAIT_MAX) begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_mem_timeout <= r_mem_timeout || (w_wait_cnt_nxt == WAIT_MAX);
    end
  end

  assign mem_timeout = r_mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  // Outside reset, ifid_flush is high only when the branch flush wins priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!w_ctrl.pc_en && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_ctrl.ifid_flush && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares them against the outputs.
module tb_hazard_ctrl_unit;

  localparam int AW = 5;
  localparam int TO = 4;
  localparam int CW = 32;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}
  localparam logic [6:0] C_RUN = 7'b11111_00;
  localparam logic [6:0] C_FRZ = 7'b00000_00;
  localparam logic [6:0] C_BR  = 7'b11111_11;
  localparam logic [6:0] C_LU  = 7'b00111_01;
  localparam logic [6:0] C_RST = 7'b11111_11;

  typedef struct packed {
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic [6:0]    ctl;
    logic          to;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } obs_t;

  typedef struct {
    string name;
    obs_t  exp;
  } item_t;

  item_t sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read, ex_branch_taken;
  logic          mem_reg_write, mem_access, mem_ready, wb_reg_write;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
  logic          mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  logic          exp_to;
  logic [CW-1:0] exp_stall;
  logic [CW-1:0] exp_flush;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_ADDR_W(AW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_rd         (mem_rd),
    .mem_reg_write  (mem_reg_write),
    .mem_access     (mem_access),
    .mem_ready      (mem_ready),
    .wb_rd          (wb_rd),
    .wb_reg_write   (wb_reg_write),
    .fwd_a_sel      (fwd_a_sel),
    .fwd_b_sel      (fwd_b_sel),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .idex_en        (idex_en),
    .exmem_en       (exmem_en),
    .memwb_en       (memwb_en),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .mem_timeout    (mem_timeout),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_rd = '0; mem_reg_write = 1'b0; mem_access = 1'b0; mem_ready = 1'b0;
    wb_rd = '0; wb_reg_write = 1'b0;
  endtask

  // Push the expectation for the cycle now being driven, then advance one cycle.
  task automatic vec(input string name, input logic [6:0] ctl,
                     input logic [1:0] fa, input logic [1:0] fb);
    item_t it;
    it.name      = name;
    it.exp.fa    = fa;
    it.exp.fb    = fb;
    it.exp.ctl   = ctl;
    it.exp.to    = exp_to;
    it.exp.stall = exp_stall;
    it.exp.flush = exp_flush;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
`ifdef HAZARD_PERF_CNT_EN
    if (rst) begin
      exp_stall = '0;
      exp_flush = '0;
    end else begin
      if (!ctl[6]) exp_stall = exp_stall + 1;
      if (ctl[1])  exp_flush = exp_flush + 1;
    end
`endif
  endtask

  task automatic freeze_inputs();
    idle();
    mem_access = 1'b1;
    mem_ready  = 1'b0;
  endtask

  // Monitor: compares every cycle that has a pending expectation.
  initial begin
    item_t it;
    obs_t  act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        it         = sb_q.pop_front();
        act.fa     = fwd_a_sel;
        act.fb     = fwd_b_sel;
        act.ctl    = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
        act.to     = mem_timeout;
        act.stall  = stall_cycles;
        act.flush  = flush_count;
        n_checks++;
        if (act !== it.exp) begin
          n_errors++;
          $display("FAIL %s: got fa=%b fb=%b ctl=%b to=%b stall=%0d flush=%0d, expected fa=%b fb=%b ctl=%b to=%b stall=%0d flush=%0d",
                   it.name, act.fa, act.fb, act.ctl, act.to, act.stall, act.flush,
                   it.exp.fa, it.exp.fb, it.exp.ctl, it.exp.to, it.exp.stall, it.exp.flush);
        end
      end
    end
  end

  initial begin
    exp_to    = 1'b0;
    exp_stall = '0;
    exp_flush = '0;
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset: selects forced to 00 even with a matching producer.
    ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_write = 1'b1;
    vec("reset_outputs", C_RST, 2'b00, 2'b00);
    rst = 1'b0;

    // Forwarding priority and x0.
    idle(); ex_rs1 = 5'd5; ex_rs2 = 5'd3; mem_rd = 5'd5; wb_rd = 5'd5;
    mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    vec("fwd_mem_wins", C_RUN, 2'b01, 2'b00);
    mem_reg_write = 1'b0;
    vec("fwd_wb", C_RUN, 2'b10, 2'b00);
    ex_rs1 = 5'd0; ex_rs2 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    vec("fwd_x0", C_RUN, 2'b00, 2'b00);
    ex_rs1 = 5'd8; ex_rs2 = 5'd9; mem_rd = 5'd8; wb_rd = 5'd9;
    vec("fwd_split", C_RUN, 2'b01, 2'b10);

    // Load-use: one bubble, then the dependent takes the WB path.
    idle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    vec("load_use_rs2", C_LU, 2'b00, 2'b00);
    idle(); ex_rs2 = 5'd7; wb_rd = 5'd7; wb_reg_write = 1'b1;
    vec("load_use_fwd_wb", C_RUN, 2'b00, 2'b10);
    idle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b0;
    vec("load_use_not_read", C_RUN, 2'b00, 2'b00);
    idle(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    vec("load_use_x0", C_RUN, 2'b00, 2'b00);
    idle(); ex_mem_read = 1'b1; ex_rd = 5'd12; id_rs1 = 5'd12; id_use_rs1 = 1'b1;
    vec("load_use_rs1", C_LU, 2'b00, 2'b00);

    // Branch beats load-use.
    ex_branch_taken = 1'b1;
    vec("branch_over_lu", C_BR, 2'b00, 2'b00);

    // Freeze defers a pending branch + load-use; branch applies on release.
    freeze_inputs(); ex_branch_taken = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd12; id_rs1 = 5'd12; id_use_rs1 = 1'b1;
    for (int i = 0; i < 3; i++) vec($sformatf("freeze_%0d", i), C_FRZ, 2'b00, 2'b00);
    mem_ready = 1'b1;
    vec("freeze_release_branch", C_BR, 2'b00, 2'b00);
    idle();
    vec("run_after_release", C_RUN, 2'b00, 2'b00);

    // Watchdog: sets after TO frozen edges, sticky after release.
    freeze_inputs();
    for (int i = 0; i < TO; i++) vec($sformatf("timeout_wait_%0d", i), C_FRZ, 2'b00, 2'b00);
    exp_to = 1'b1;
    mem_ready = 1'b1;
    vec("timeout_set", C_RUN, 2'b00, 2'b00);
    idle();
    vec("timeout_sticky", C_RUN, 2'b00, 2'b00);
    rst = 1'b1;
    vec("timeout_in_reset", C_RST, 2'b00, 2'b00);
    rst = 1'b0;
    exp_to = 1'b0;
    vec("timeout_cleared", C_RUN, 2'b00, 2'b00);

    // Reset mid-wait must clear the wait counter.
    freeze_inputs();
    vec("midwait_0", C_FRZ, 2'b00, 2'b00);
    vec("midwait_1", C_FRZ, 2'b00, 2'b00);
    rst = 1'b1;
    vec("midwait_reset", C_RST, 2'b00, 2'b00);
    rst = 1'b0;
    for (int i = 0; i < TO; i++) vec($sformatf("post_reset_wait_%0d", i), C_FRZ, 2'b00, 2'b00);
    exp_to = 1'b1;
    mem_ready = 1'b1;
    vec("post_reset_timeout", C_RUN, 2'b00, 2'b00);
    idle();

    @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
